// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO input path: interrupt event
// encoding, synchronizer depth limits and the per-pin event decoder.
package gpio_pkg;

    typedef enum logic [1:0] {
        GPIO_INT_RISE  = 2'b00,
        GPIO_INT_FALL  = 2'b01,
        GPIO_INT_BOTH  = 2'b10,
        GPIO_INT_LEVEL = 2'b11
    } gpio_int_type_e;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // s is the current synchronized value, p the value one cycle earlier
    function automatic logic gpio_event(input gpio_int_type_e int_type,
                                        input logic s,
                                        input logic p);
        logic evt;
        evt = 1'b0;
        case (int_type)
            GPIO_INT_RISE:  evt = s & ~p;
            GPIO_INT_FALL:  evt = ~s & p;
            GPIO_INT_BOTH:  evt = s ^ p;
            GPIO_INT_LEVEL: evt = s;
            default:        evt = 1'b0;
        endcase
        return evt;
    endfunction

endpackage

// File: rtl/gpio_pin_filter.sv
// Single-pin synchronizer with an optional debounce filter behind it.
// The filter is built only when GPIO_DEBOUNCE_EN is defined.
module gpio_pin_filter
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                pin_i,
    input  logic [DB_CNT_W-1:0] db_cnt_max_i,
    output logic                pin_o
);

    if ((SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX)) begin : g_bad_depth
        $fatal(1, "gpio_pin_filter: SYNC_STAGES must be in 2..4");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    logic                filt_q;
    logic [DB_CNT_W-1:0] cnt_q;

    // >= rather than == so a threshold lowered mid-count still releases the filter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else if (sync_s != filt_q) begin
            if (cnt_q >= db_cnt_max_i) begin
                filt_q <= sync_s;
                cnt_q  <= '0;
            end else if (cnt_q != {DB_CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + DB_CNT_W'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign pin_o = filt_q;
`else
    logic unused_db_cnt;

    assign unused_db_cnt = ^db_cnt_max_i;
    assign pin_o         = sync_s;
`endif

endmodule

// File: rtl/gpio_in_sync_irq.sv
// GPIO input synchronizer, per-pin event detection, sticky status and
// registered aggregated interrupt. Optional debounce: GPIO_DEBOUNCE_EN.
module gpio_in_sync_irq
    import gpio_pkg::*;
#(
    parameter int NUM_GPIO    = 64,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT_W    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_GPIO-1:0]   gpio_in_i,
    output logic [NUM_GPIO-1:0]   gpio_in_sync_o,
    input  logic [NUM_GPIO-1:0]   int_en_i,
    input  logic [2*NUM_GPIO-1:0] int_type_i,
    input  logic [NUM_GPIO-1:0]   int_clr_i,
    input  logic [DB_CNT_W-1:0]   db_cnt_max_i,
    output logic [NUM_GPIO-1:0]   int_status_o,
    output logic                  irq_o
);

    logic [NUM_GPIO-1:0] prev_q;
    logic [NUM_GPIO-1:0] int_status_q;
    logic [NUM_GPIO-1:0] evt;
    logic                irq_q;

    for (genvar g = 0; g < NUM_GPIO; g++) begin : g_pin
        gpio_pin_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CNT_W    (DB_CNT_W)
        ) u_filter (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .pin_i        (gpio_in_i[g]),
            .db_cnt_max_i (db_cnt_max_i),
            .pin_o        (gpio_in_sync_o[g])
        );
    end

    always_comb begin
        evt = '0;
        for (int i = 0; i < NUM_GPIO; i++) begin
            evt[i] = int_en_i[i] &
                     gpio_event(gpio_int_type_e'(int_type_i[2*i +: 2]),
                                gpio_in_sync_o[i], prev_q[i]);
        end
    end

    // prev_q tracks regardless of enable so enabling a pin never sees a stale edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q       <= '0;
            int_status_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            prev_q       <= gpio_in_sync_o;
            int_status_q <= evt | (int_status_q & ~int_clr_i);
            irq_q        <= |(int_status_q & int_en_i);
        end
    end

    assign int_status_o = int_status_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_gpio_in_sync_irq.sv
// Self-checking bench for gpio_in_sync_irq: vector table, directed corner
// sequences and randomized traffic against a delay-line reference model.
module tb_gpio_in_sync_irq;

    localparam int N  = 64;
    localparam int SS = 2;
    localparam int DW = 16;
`ifdef GPIO_DEBOUNCE_EN
    localparam int D = SS + 1;
`else
    localparam int D = SS;
`endif

    localparam logic [N-1:0]   B0  = 64'h1;
    localparam logic [N-1:0]   B3  = 64'h8;
    localparam logic [N-1:0]   B5  = 64'h20;
    localparam logic [N-1:0]   B7  = 64'h80;
    localparam logic [N-1:0]   B10 = 64'h400;
    localparam logic [2*N-1:0] T5F = 128'h1 << 10;
    localparam logic [2*N-1:0] T7B = 128'h2 << 14;
    localparam logic [2*N-1:0] T10L = 128'h3 << 20;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   gin = '0;
    logic [N-1:0]   en = '0;
    logic [N-1:0]   clr = '0;
    logic [2*N-1:0] typ = '0;
    logic [DW-1:0]  dbmax = '0;
    logic [N-1:0]   sync_o;
    logic [N-1:0]   status_o;
    logic           irq;

    gpio_in_sync_irq #(.NUM_GPIO(N), .SYNC_STAGES(SS), .DB_CNT_W(DW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .gpio_in_i      (gin),
        .gpio_in_sync_o (sync_o),
        .int_en_i       (en),
        .int_type_i     (typ),
        .int_clr_i      (clr),
        .db_cnt_max_i   (dbmax),
        .int_status_o   (status_o),
        .irq_o          (irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit model_on = 1'b1;

    // reference: the visible input is the pad value delayed D cycles
    logic [N-1:0] m_pipe [D];
    logic [N-1:0] m_sync, m_prev, m_status;
    logic         m_irq;

    typedef struct {
        logic [N-1:0]   gin;
        logic [N-1:0]   en;
        logic [2*N-1:0] typ;
        logic [N-1:0]   clr;
        logic [N-1:0]   exp_sync;
        logic [N-1:0]   exp_status;
        logic           exp_irq;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic [N-1:0] g, input logic [N-1:0] e,
                                input logic [2*N-1:0] t, input logic [N-1:0] c,
                                input logic [N-1:0] es, input logic [N-1:0] est,
                                input logic ei);
        vec_t v;
        v.gin = g; v.en = e; v.typ = t; v.clr = c;
        v.exp_sync = es; v.exp_status = est; v.exp_irq = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic pin_event(input logic [1:0] t, input logic s, input logic p);
        case (t)
            2'd0:    return s && !p;
            2'd1:    return !s && p;
            2'd2:    return s != p;
            default: return s;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < D; k++) m_pipe[k] = '0;
        m_sync = '0; m_prev = '0; m_status = '0; m_irq = 1'b0;
    endtask

    // one clock: capture inputs, advance the model, compare 1 ns after the edge
    task automatic cyc();
        logic [N-1:0]   c_gin, c_en, c_clr, n_status;
        logic [2*N-1:0] c_typ;
        c_gin = gin; c_en = en; c_clr = clr; c_typ = typ;
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (c_en[i] && pin_event(c_typ[2*i +: 2], m_sync[i], m_prev[i]))
                    n_status[i] = 1'b1;
                else if (c_clr[i])
                    n_status[i] = 1'b0;
                else
                    n_status[i] = m_status[i];
            end
            m_irq    = |(m_status & c_en);
            m_status = n_status;
            m_prev   = m_sync;
            for (int k = D - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
            m_pipe[0] = c_gin;
            m_sync    = m_pipe[D-1];
        end
        #1;
        if (model_on) begin
            chk("model_sync", sync_o, m_sync);
            chk("model_status", status_o, m_status);
            chk("model_irq", {63'b0, irq}, {63'b0, m_irq});
        end
    endtask

    task automatic hit_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_sync", sync_o, '0);
        chk("rst_status", status_o, '0);
        chk("rst_irq", {63'b0, irq}, '0);
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        chk("por_sync", sync_o, '0);
        chk("por_status", status_o, '0);
        chk("por_irq", {63'b0, irq}, '0);
        #10;
        rst_n = 1'b1;

`ifndef GPIO_DEBOUNCE_EN
        // pin 3 rising latency, then pin 5 falling with clear/set collision
        tbl[0]  = mk(B3,      B3, '0,  '0, '0,      '0, 1'b0);
        tbl[1]  = mk(B3,      B3, '0,  '0, B3,      '0, 1'b0);
        tbl[2]  = mk(B3,      B3, '0,  '0, B3,      B3, 1'b0);
        tbl[3]  = mk(B3,      B3, '0,  '0, B3,      B3, 1'b1);
        tbl[4]  = mk(B3 | B5, B5, T5F, B3, B3,      '0, 1'b0);
        tbl[5]  = mk(B3 | B5, B5, T5F, '0, B3 | B5, '0, 1'b0);
        tbl[6]  = mk(B3,      B5, T5F, '0, B3 | B5, '0, 1'b0);
        tbl[7]  = mk(B3,      B5, T5F, '0, B3,      '0, 1'b0);
        tbl[8]  = mk(B3 | B5, B5, T5F, '0, B3,      B5, 1'b0);
        tbl[9]  = mk(B3,      B5, T5F, '0, B3 | B5, B5, 1'b1);
        tbl[10] = mk(B3,      B5, T5F, '0, B3,      B5, 1'b1);
        tbl[11] = mk(B3,      B5, T5F, B5, B3,      B5, 1'b1);
        tbl[12] = mk(B3,      B5, T5F, B5, B3,      '0, 1'b1);
        tbl[13] = mk(B3,      B5, T5F, '0, B3,      '0, 1'b0);
        for (int r = 0; r < 14; r++) begin
            gin = tbl[r].gin; en = tbl[r].en; typ = tbl[r].typ; clr = tbl[r].clr;
            cyc();
            chk($sformatf("tbl%0d_sync", r), sync_o, tbl[r].exp_sync);
            chk($sformatf("tbl%0d_status", r), status_o, tbl[r].exp_status);
            chk($sformatf("tbl%0d_irq", r), {63'b0, irq}, {63'b0, tbl[r].exp_irq});
        end
`endif
        clr = '0;

        // level type: clear is overridden while the input stays high
        en = B10; typ = T10L; gin = B3 | B10;
        repeat (5) cyc();
        chk("lvl_set", {63'b0, status_o[10]}, 64'h1);
        clr = B10; cyc(); clr = '0;
        chk("lvl_clr_high", {63'b0, status_o[10]}, 64'h1);
        gin = B3;
        repeat (5) cyc();
        clr = B10; cyc(); clr = '0;
        chk("lvl_clr_low", {63'b0, status_o[10]}, 64'h0);

        // disabled pin toggling produces nothing; masking drops irq but keeps status
        en = '0; typ = T7B;
        for (int k = 0; k < 6; k++) begin gin = gin ^ B7; cyc(); end
        gin = B3;
        repeat (5) cyc();
        en = B7;
        repeat (4) cyc();
        chk("dis_no_status", {63'b0, status_o[7]}, 64'h0);
        gin = B3 | B7;
        repeat (5) cyc();
        chk("both_set", {63'b0, status_o[7]}, 64'h1);
        chk("both_irq", {63'b0, irq}, 64'h1);
        en = '0; cyc();
        chk("mask_irq", {63'b0, irq}, 64'h0);
        chk("mask_keep", {63'b0, status_o[7]}, 64'h1);

        // reset while irq is active and inputs toggle
        en = B7;
        repeat (2) cyc();
        for (int k = 0; k < 3; k++) begin gin = {$urandom, $urandom} & ~B7; cyc(); end
        chk("pre_rst_irq", {63'b0, irq}, 64'h1);
        gin = B3; typ = '0; en = B3; clr = '0;
        hit_reset();
        repeat (6) cyc();
        chk("post_rst_event", {63'b0, status_o[3]}, 64'h1);
        clr = B3; cyc(); clr = '0;
        repeat (4) cyc();
        chk("post_rst_single", {63'b0, status_o[3]}, 64'h0);

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            if (c % 16 == 0) begin
                en  = {$urandom, $urandom};
                typ = {$urandom, $urandom, $urandom, $urandom};
            end
            gin = (c % 3 == 0) ? {$urandom, $urandom} : gin ^ ({$urandom, $urandom} & {$urandom, $urandom});
            clr = {$urandom, $urandom} & {$urandom, $urandom};
            cyc();
        end
        clr = '0;

`ifdef GPIO_DEBOUNCE_EN
        // debounce: short glitch rejected, stable level accepted once
        model_on = 1'b0;
        gin = '0; en = B0; typ = '0; dbmax = 16'd4;
        hit_reset();
        repeat (3) cyc();
        gin = B0; repeat (3) cyc();
        gin = '0; repeat (12) cyc();
        chk("db_glitch_sync", {63'b0, sync_o[0]}, 64'h0);
        chk("db_glitch_status", {63'b0, status_o[0]}, 64'h0);
        gin = B0; repeat (12) cyc();
        chk("db_stable_sync", {63'b0, sync_o[0]}, 64'h1);
        chk("db_stable_status", {63'b0, status_o[0]}, 64'h1);
        clr = B0; cyc(); clr = '0;
        repeat (4) cyc();
        chk("db_single_event", {63'b0, status_o[0]}, 64'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
